regfile_wb_arbiter: RTL

Writeback arbiter and post-reset sequencer for the 32×32 register file. Two writeback requesters, port A (ALU) and port B (load unit), share the register file's single synchronous write port through a valid/ready handshake with round-robin arbitration. After reset, an optional sweep writes zero to registers 1..NUM_REGS-1, because the register file's own reset clears only register 0. The block sits between the execute/memory stages and the register file write port.

---
 rtl/regfile_wb_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Round-robin writeback arbiter for a two-requester register file
//            write port, with an optional post-reset clear sweep
//            (compile with WB_INIT_CLEAR_EN to enable the sweep).
// Revision : 1.0
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              init_done,
    output logic [15:0]       conflict_cnt
);

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    if (NUM_REGS < 2 || NUM_REGS > (1 << ADDR_W)) begin : g_bad_num_regs
        $error("NUM_REGS must lie in 2..2**ADDR_W");
    end

    logic in_run;
    logic last_grant;
    logic a_xfer;
    logic b_xfer;
    logic both_valid;

`ifdef WB_INIT_CLEAR_EN
    localparam logic [0:0]        ST_INIT  = 1'b0;
    localparam logic [0:0]        ST_RUN   = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [ADDR_W-1:0] idx;

    always_ff @(posedge clk or posedge rst) begin : p_state
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin : p_next_state
        state_nxt = state;
        if (state == ST_INIT && idx == LAST_IDX) begin
            state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin : p_idx
        if (rst) begin
            idx <= ADDR_W'(1);
        end else if (state == ST_INIT) begin
            idx <= idx + ADDR_W'(1);
        end
    end

    assign in_run = (state == ST_RUN);
`else
    assign in_run = 1'b1;
`endif

    // Readiness is suppressed while rst is high so nothing is accepted
    // during a reset pulse that lands mid-cycle.
    always_comb begin : p_outputs
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst && in_run) begin
            if (a_valid && b_valid) begin
                a_ready = (last_grant == GNT_B);
                b_ready = (last_grant == GNT_A);
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
        end
    end

    assign a_xfer     = a_valid && a_ready;
    assign b_xfer     = b_valid && b_ready;
    assign both_valid = a_valid && b_valid;
    assign init_done  = in_run;

    always_ff @(posedge clk or posedge rst) begin : p_writeback
        if (rst) begin
            RegWrite     <= 1'b0;
            WriteReg     <= '0;
            WriteData    <= '0;
            last_grant   <= GNT_B;
            conflict_cnt <= '0;
`ifdef WB_INIT_CLEAR_EN
        end else if (!in_run) begin
            RegWrite  <= 1'b1;
            WriteReg  <= idx;
            WriteData <= '0;
`endif
        end else begin
            // Register 0 is hardwired: the transfer completes but no write fires.
            if (a_xfer) begin
                RegWrite   <= (a_reg != '0);
                WriteReg   <= a_reg;
                WriteData  <= a_data;
                last_grant <= GNT_A;
            end else if (b_xfer) begin
                RegWrite   <= (b_reg != '0);
                WriteReg   <= b_reg;
                WriteData  <= b_data;
                last_grant <= GNT_B;
            end else begin
                RegWrite <= 1'b0;
            end
            if (both_valid && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire
